// File: rtl/fll_cfg_master.sv
// rtl/fll_cfg_master.sv - Command-to-FLL config bridge using a 4-phase req/ack handshake
//
// Optional feature: define FLL_CFG_TIMEOUT_EN to enable the handshake timeout.
// If the timeout fires, the response is returned with rsp_err_o=1 and rsp_rdata_o=0.
//
// Ports:
//   clk_i, rst_i            - block clock and synchronous active-high reset
//   cmd_valid_i/cmd_ready_o - upstream command handshake (cmd_we_i, cmd_addr_i, cmd_wdata_i)
//   rsp_valid_o/rsp_ready_i - upstream response handshake (rsp_rdata_o, rsp_err_o)
//   fll_req_o/fll_ack_i     - FLL config handshake; the ack is asynchronous to clk_i
//   fll_addr_o, fll_wdata_o, fll_web_o, fll_rdata_i - FLL config bus (web is active low)

module fll_cfg_master #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  fll_req_o,
    input  logic                  fll_ack_i,
    output logic [ADDR_WIDTH-1:0] fll_addr_o,
    output logic [DATA_WIDTH-1:0] fll_wdata_o,
    output logic                  fll_web_o,
    input  logic [DATA_WIDTH-1:0] fll_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, ACK_LOW, RSP} state_t;

    state_t state, state_nxt;
    logic   ack_q1, ack_s;
    logic   accept;
    logic   busy;
    logic   tmo_hit;

    // Two-flop synchronizer for the asynchronous ack
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q1 <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            ack_q1 <= fll_ack_i;
            ack_s  <= ack_q1;
        end
    end

    assign accept = cmd_valid_i && cmd_ready_o;
    assign busy   = (state == REQ) || (state == ACK_LOW);

`ifdef FLL_CFG_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        err_q;

    assign tmo_hit = busy && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else if (tmo_hit) begin
            err_q   <= 1'b1;
        end else if (busy) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign rsp_err_o = err_q;
`else
    assign tmo_hit   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a timeout takes priority over the ack in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)       state_nxt = REQ;
            REQ:     if (tmo_hit)      state_nxt = RSP;
                     else if (ack_s)   state_nxt = ACK_LOW;
            ACK_LOW: if (tmo_hit || !ack_s) state_nxt = RSP;
            RSP:     if (rsp_ready_i)  state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state. Ready is held low while reset is applied and
    // while a stale ack from a previous transaction is still high.
    always_comb begin
        cmd_ready_o = (state == IDLE) && !ack_s && !rst_i;
        fll_req_o   = (state == REQ);
        rsp_valid_o = (state == RSP);
    end

    // Config bus and response data registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fll_addr_o  <= '0;
            fll_wdata_o <= '0;
            fll_web_o   <= 1'b1;
            rsp_rdata_o <= '0;
        end else if (accept) begin
            fll_addr_o  <= cmd_addr_i;
            fll_wdata_o <= cmd_wdata_i;
            fll_web_o   <= ~cmd_we_i;
            rsp_rdata_o <= '0;
        end else if (tmo_hit) begin
            rsp_rdata_o <= '0;
        end else if ((state == REQ) && ack_s) begin
            rsp_rdata_o <= fll_web_o ? fll_rdata_i : '0;
        end
    end

endmodule

// File: tb/tb_fll_cfg_master.sv
// tb/tb_fll_cfg_master.sv - Directed self-checking bench for fll_cfg_master
module tb_fll_cfg_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [1:0]  cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        fll_req_o, fll_ack_i, fll_web_o;
    logic [1:0]  fll_addr_o;
    logic [31:0] fll_wdata_o, fll_rdata_i;

    int errors = 0;
    int checks = 0;
    int saw_rsp;

    always #5 clk = ~clk;

    fll_cfg_master #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .fll_req_o(fll_req_o), .fll_ack_i(fll_ack_i),
        .fll_addr_o(fll_addr_o), .fll_wdata_o(fll_wdata_o),
        .fll_web_o(fll_web_o), .fll_rdata_i(fll_rdata_i)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called right after the acceptance edge; the FLL acks 3 cycles after req.
    // Expected timing: ack seen after 2 sync edges, req drops on the next edge,
    // and the response appears 3 edges after ack falls (9 cycles total).
    task automatic handshake(input logic [31:0] rdata);
        tick(3);
        fll_ack_i   = 1'b1;
        fll_rdata_i = rdata;
        tick(2);
        chk("req_held_until_ack_s", {31'd0, fll_req_o}, 32'd1);
        tick(1);
        chk("req_drop_after_ack_s", {31'd0, fll_req_o}, 32'd0);
        chk("no_rsp_in_ack_low", {31'd0, rsp_valid_o}, 32'd0);
        fll_ack_i   = 1'b0;
        tick(2);
        fll_rdata_i = 32'hDEAD_BEEF;
        chk("no_rsp_before_ack_low_sync", {31'd0, rsp_valid_o}, 32'd0);
        tick(1);
        chk("rsp_valid_latency", {31'd0, rsp_valid_o}, 32'd1);
        chk("req_rsp_exclusive", {31'd0, fll_req_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = 2'd0;
        cmd_wdata_i = 32'd0; rsp_ready_i = 1'b0; fll_ack_i = 1'b0; fll_rdata_i = 32'd0;
        tick(3);
        chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_fll_req", {31'd0, fll_req_o}, 32'd0);
        chk("rst_fll_web", {31'd0, fll_web_o}, 32'd1);
        chk("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_fll_addr", {30'd0, fll_addr_o}, 32'd0);
        chk("rst_fll_wdata", fll_wdata_o, 32'd0);
        rst_i = 1'b0;
        tick(1);
        chk("idle_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);

        // Write addr=2
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 2'd2; cmd_wdata_i = 32'hC00D_0001;
        tick(1);
        cmd_valid_i = 1'b0;
        chk("wr_req_first_cycle", {31'd0, fll_req_o}, 32'd1);
        chk("wr_web", {31'd0, fll_web_o}, 32'd0);
        chk("wr_addr", {30'd0, fll_addr_o}, 32'd2);
        chk("wr_wdata", fll_wdata_o, 32'hC00D_0001);
        chk("wr_busy_not_ready", {31'd0, cmd_ready_o}, 32'd0);
        handshake(32'h5555_AAAA);
        chk("wr_rsp_rdata_zero", rsp_rdata_o, 32'd0);
        chk("wr_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        chk("wr_addr_held", {30'd0, fll_addr_o}, 32'd2);
        rsp_ready_i = 1'b1;
        tick(1);
        rsp_ready_i = 1'b0;
        chk("wr_rsp_consumed", {31'd0, rsp_valid_o}, 32'd0);
        chk("wr_back_idle_ready", {31'd0, cmd_ready_o}, 32'd1);

        // Read addr=1
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 2'd1; cmd_wdata_i = 32'h0;
        tick(1);
        cmd_valid_i = 1'b0;
        chk("rd_web", {31'd0, fll_web_o}, 32'd1);
        chk("rd_addr", {30'd0, fll_addr_o}, 32'd1);
        handshake(32'h8000_05F5);
        chk("rd_rsp_rdata", rsp_rdata_o, 32'h8000_05F5);
        chk("rd_rsp_err", {31'd0, rsp_err_o}, 32'd0);

        // Response stall with a pending second command
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 2'd3; cmd_wdata_i = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("stall_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
            chk("stall_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("stall_rsp_rdata", rsp_rdata_o, 32'h8000_05F5);
            chk("stall_rsp_err", {31'd0, rsp_err_o}, 32'd0);
            chk("stall_fll_req", {31'd0, fll_req_o}, 32'd0);
            chk("stall_addr_held", {30'd0, fll_addr_o}, 32'd1);
        end
        rsp_ready_i = 1'b1;
        tick(1);
        rsp_ready_i = 1'b0;
        chk("second_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        tick(1);
        cmd_valid_i = 1'b0;
        chk("second_req", {31'd0, fll_req_o}, 32'd1);
        chk("second_addr", {30'd0, fll_addr_o}, 32'd3);
        chk("second_web", {31'd0, fll_web_o}, 32'd0);
        handshake(32'h0F0F_0F0F);
        chk("second_rsp_rdata", rsp_rdata_o, 32'd0);
        rsp_ready_i = 1'b1;
        tick(1);
        rsp_ready_i = 1'b0;

        // Reset while in REQ
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 2'd1; cmd_wdata_i = 32'hABCD_0000;
        tick(1);
        cmd_valid_i = 1'b0;
        tick(1);
        chk("abort_req_before", {31'd0, fll_req_o}, 32'd1);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        chk("abort_req_dropped", {31'd0, fll_req_o}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("abort_web", {31'd0, fll_web_o}, 32'd1);
        chk("abort_addr", {30'd0, fll_addr_o}, 32'd0);
        saw_rsp = 0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (rsp_valid_o || fll_req_o) saw_rsp++;
        end
        rsp_ready_i = 1'b0;
        chk("abort_no_response", saw_rsp, 32'd0);
        chk("abort_idle_ready", {31'd0, cmd_ready_o}, 32'd1);

`ifdef FLL_CFG_TIMEOUT_EN
        // Timeout: ack never arrives
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 2'd2;
        tick(1);
        cmd_valid_i = 1'b0;
        tick(15);
        chk("tmo_not_yet", {31'd0, rsp_valid_o}, 32'd0);
        chk("tmo_req_still", {31'd0, fll_req_o}, 32'd1);
        tick(1);
        chk("tmo_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("tmo_rsp_err", {31'd0, rsp_err_o}, 32'd1);
        chk("tmo_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("tmo_req_low", {31'd0, fll_req_o}, 32'd0);
        rsp_ready_i = 1'b1;
        tick(1);
        rsp_ready_i = 1'b0;
        chk("tmo_idle_ready", {31'd0, cmd_ready_o}, 32'd1);
        // Late ack after the timeout blocks new commands until it falls
        fll_ack_i = 1'b1;
        tick(2);
        chk("late_ack_not_ready", {31'd0, cmd_ready_o}, 32'd0);
        fll_ack_i = 1'b0;
        tick(2);
        chk("late_ack_ready_again", {31'd0, cmd_ready_o}, 32'd1);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 2'd1;
        tick(1);
        cmd_valid_i = 1'b0;
        handshake(32'h0000_1234);
        chk("post_tmo_rdata", rsp_rdata_o, 32'h0000_1234);
        chk("post_tmo_err", {31'd0, rsp_err_o}, 32'd0);
        rsp_ready_i = 1'b1;
        tick(1);
        rsp_ready_i = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fll_cfg_master.md
FLL_CFG_MASTER -- requirements
Module: fll_cfg_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, SHALL set the FLL config address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the FLL config data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the handshake timeout in clk_i cycles; legal range 4..65535.
REQ-004 clk_i  in  1  SHALL be the single block clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 cmd_valid_i  in  1  SHALL flag a pending upstream command.
REQ-007 cmd_ready_o  out  1  SHALL flag that a command is accepted this cycle.
REQ-008 cmd_we_i  in  1  SHALL select write when 1, read when 0.
REQ-009 cmd_addr_i  in  ADDR_WIDTH  SHALL carry the FLL register address.
REQ-010 cmd_wdata_i  in  DATA_WIDTH  SHALL carry the write data.
REQ-011 rsp_valid_o  out  1  SHALL flag a valid response.
REQ-012 rsp_ready_i  in  1  SHALL flag that upstream consumes the response.
REQ-013 rsp_rdata_o  out  DATA_WIDTH  SHALL carry the read data; 0 for writes and errors.
REQ-014 rsp_err_o  out  1  SHALL flag a timed-out transaction.
REQ-015 fll_req_o  out  1  SHALL drive the FLL config request, active high.
REQ-016 fll_ack_i  in  1  SHALL be the FLL config acknowledge, asynchronous to clk_i.
REQ-017 fll_addr_o  out  ADDR_WIDTH, fll_wdata_o  out  DATA_WIDTH, fll_web_o  out  1 (write enable, active low) SHALL drive the FLL config address, data and write enable.
REQ-018 fll_rdata_i  in  DATA_WIDTH  SHALL be the FLL read data, stable while synchronized ack is high.

Function
REQ-019 fll_ack_i SHALL pass through a 2-flop synchronizer; ack_s denotes its output; all decisions SHALL use ack_s.
REQ-020 The FSM SHALL have the states IDLE, REQ, ACK_LOW and RSP.
REQ-021 cmd_ready_o SHALL be 1 only in IDLE with ack_s==0.
REQ-022 On acceptance, the FSM SHALL register addr, wdata and web=~cmd_we_i, clear the timeout counter and enter REQ.
REQ-023 fll_req_o SHALL be 1 exactly while in REQ, first high the cycle after acceptance.
REQ-024 fll_addr_o, fll_wdata_o and fll_web_o SHALL hold the registered values from acceptance until the next acceptance; fll_web_o SHALL be 1 out of reset.
REQ-025 REQ SHALL go to ACK_LOW on ack_s==1, capturing fll_rdata_i into rsp_rdata_o on reads and capturing 0 on writes.
REQ-026 ACK_LOW SHALL go to RSP on ack_s==0 (4-phase handshake complete).
REQ-027 In RSP, rsp_valid_o SHALL be 1, rsp_rdata_o and rsp_err_o SHALL be stable, and the FSM SHALL return to IDLE in the cycle rsp_ready_i==1.
REQ-028 Only one transaction SHALL be outstanding; no new command is accepted before the RSP handshake.
REQ-029 Nominal latency from acceptance to rsp_valid_o SHALL be the FLL ack delay plus 4 sync cycles plus 2 cycles.
REQ-030 rsp_valid_o and fll_req_o SHALL never be 1 in the same cycle.

Reset
REQ-031 With rst_i==1 at a clock edge, the FSM SHALL enter IDLE and all outputs SHALL become 0, except fll_web_o=1; the synchronizer and timeout counter SHALL clear.
REQ-032 Reset asserted mid-transaction SHALL drop fll_req_o on the next edge and discard the pending response.
REQ-033 After reset, cmd_ready_o SHALL stay 0 until ack_s==0, per REQ-021.

Configuration
REQ-034 With macro FLL_CFG_TIMEOUT_EN defined, a counter SHALL increment each cycle in REQ or ACK_LOW; reaching TIMEOUT_CYCLES-1 SHALL force RSP with rsp_err_o=1, rsp_rdata_o=0 and fll_req_o=0.
REQ-035 Without FLL_CFG_TIMEOUT_EN, the counter SHALL be absent, REQ and ACK_LOW SHALL wait indefinitely, and rsp_err_o SHALL be constant 0.

Verification
REQ-036 Write addr=2, wdata=0xC00D_0001; FLL model acks 3 cycles after req -> fll_web_o=0, req drops after ack_s, rsp_valid_o=1 with rsp_err_o=0 and rsp_rdata_o=0.
REQ-037 Read addr=1; model returns 0x8000_05F5 -> rsp_rdata_o=0x8000_05F5 and rsp_err_o=0.
REQ-038 rsp_ready_i held 0 for 10 cycles with cmd_valid_i=1 -> cmd_ready_o=0 and rsp_* stable throughout; a second command is accepted only after the RSP handshake.
REQ-039 FLL_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never asserted -> rsp_err_o=1 at cycle 16 after req; cmd_ready_o=1 in IDLE.
REQ-040 FLL_CFG_TIMEOUT_EN, ack raised late after a timeout -> cmd_ready_o=0 while ack_s==1; the next command proceeds normally after ack falls.
REQ-041 rst_i pulsed while in REQ -> the next edge gives fll_req_o=0, rsp_valid_o=0 and fll_web_o=1; no response is ever produced for the aborted command.
